timer_counter: RTL



---
 rtl/timer_counter_pkg.sv | 28 ++
 rtl/timer_counter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/timer_counter_pkg.sv
// Shared constants for the memory-mapped down-counting timer: register
// offsets, CTRL bit positions, MODE encodings and FSM state encodings.
package timer_counter_pkg;

   // Register offsets as decoded from addr[3:2]
   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PRESET = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;

   // CTRL bit indices
   localparam int CTRL_EN      = 0;
   localparam int CTRL_MODE_LO = 1;
   localparam int CTRL_MODE_HI = 2;
   localparam int CTRL_IM      = 3;

   // MODE encodings; 2'b10 and 2'b11 are reserved and act as one-shot
   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   // Timer FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } state_t;

endpackage : timer_counter_pkg

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer. CTRL/PRESET are written by the CPU
// bridge, COUNT is read-only. The FSM loads PRESET into COUNT, counts down
// to zero and raises an interrupt flag; the flag is gated by CTRL.IM.
module timer_counter
   import timer_counter_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      addr,
   input  logic             we,
   input  logic [CNT_W-1:0] wd,
   output logic [CNT_W-1:0] rd,
   output logic             irq
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [3:0]       ctrl_r;
   logic [CNT_W-1:0] preset_r;
   logic [CNT_W-1:0] count_r;
   logic             irq_flag_r;
   state_t           state_r;

   logic             wr_ctrl_s;
   logic             wr_preset_s;
   logic [1:0]       mode_s;
   logic             unused_addr_s;

   // Only addr[3:2] selects a register; the bridge has already range-qualified we
   assign unused_addr_s = ^{addr[31:4], addr[1:0]};
   assign mode_s        = ctrl_r[CTRL_MODE_HI:CTRL_MODE_LO];

   // Decode software write strobes for the two writable registers
   always_comb begin
      wr_ctrl_s   = 1'b0;
      wr_preset_s = 1'b0;
      if (we) begin
         case (addr[3:2])
            REG_CTRL:   wr_ctrl_s   = 1'b1;
            REG_PRESET: wr_preset_s = 1'b1;
            default: begin
               wr_ctrl_s   = 1'b0;
               wr_preset_s = 1'b0;
            end
         endcase
      end else begin
         wr_ctrl_s   = 1'b0;
         wr_preset_s = 1'b0;
      end
   end

   // Register file and timer FSM. Statement order sets priority: a software
   // write clears the flag but an FSM set in the same cycle wins, while a
   // software CTRL write overrides the one-shot EN clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl_r     <= 4'd0;
         preset_r   <= CNT_ZERO;
         count_r    <= CNT_ZERO;
         irq_flag_r <= 1'b0;
         state_r    <= ST_IDLE;
      end else begin
         if (wr_ctrl_s || wr_preset_s) begin
            irq_flag_r <= 1'b0;
         end

         case (state_r)
            ST_IDLE: begin
               if (ctrl_r[CTRL_EN]) begin
                  state_r <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               count_r <= preset_r;
               state_r <= ST_CNT;
            end
            ST_CNT: begin
               if (!ctrl_r[CTRL_EN]) begin
                  state_r <= ST_IDLE;
               end else if (count_r > CNT_ONE) begin
                  count_r <= count_r - CNT_ONE;
               end else begin
                  // PRESET=0 lands here on the first CNT cycle, same as PRESET=1
                  count_r    <= CNT_ZERO;
                  irq_flag_r <= 1'b1;
                  state_r    <= ST_INT;
               end
            end
            ST_INT: begin
               if (mode_s == MODE_RELOAD) begin
                  // EN stays set, so IDLE reloads and irq is a single-cycle pulse
                  irq_flag_r <= 1'b0;
               end else begin
                  // One-shot and reserved modes: stop and hold the flag
                  ctrl_r[CTRL_EN] <= 1'b0;
               end
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase

         if (wr_ctrl_s) begin
            ctrl_r <= wd[3:0];
         end
         if (wr_preset_s) begin
            preset_r <= wd;
         end
      end
   end

   // Combinational read mux; reads have no side effects
   always_comb begin
      rd = CNT_ZERO;
      case (addr[3:2])
         REG_CTRL:   rd = {{(CNT_W-4){1'b0}}, ctrl_r};
         REG_PRESET: rd = preset_r;
         REG_COUNT:  rd = count_r;
         default:    rd = CNT_ZERO;
      endcase
   end

   assign irq = irq_flag_r & ctrl_r[CTRL_IM];

endmodule : timer_counter
